// File: rtl/mar_ram_unit.sv
// Memory stage between the bus and the MDR: MAR register, synchronous single-port RAM and a
// multi-cycle read/write controller with a programmable number of wait states.
module mar_ram_unit #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  MARin,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic [DATA_WIDTH-1:0] mar_q,
  output logic                  mem_busy,
  output logic                  mem_ready,
  output logic                  addr_err,
  output logic                  req_err
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_isRead;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mar;
  logic [DATA_WIDTH-1:0] r_mdata;
  logic                  r_busy;
  logic                  r_ready;
  logic                  r_addrErr;
  logic                  r_reqErr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_start;
  logic                  w_conflict;
  logic [DATA_WIDTH-1:0] w_reqAddr;
  logic                  w_addrValid;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_doWrite;

  assign w_start     = Read ^ Write;
  assign w_conflict  = Read & Write;
  assign w_reqAddr   = MARin ? bus_in : r_mar;
  // High address bits flag an error rather than aliasing onto a lower word.
  assign w_addrValid = (r_addr[DATA_WIDTH-1:ADDR_WIDTH] == '0);
  assign w_index     = r_addr[ADDR_WIDTH-1:0];
  assign w_doWrite   = !clr && (r_state == S_ACCESS) && !r_isRead && w_addrValid;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_isRead  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mar     <= '0;
      r_mdata   <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_addrErr <= 1'b0;
      r_reqErr  <= 1'b0;
    end else begin
      r_ready   <= 1'b0;
      r_addrErr <= 1'b0;
      r_reqErr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MARin) r_mar <= bus_in;
          if (w_conflict) begin
            r_reqErr <= 1'b1;
          end else if (w_start) begin
            r_isRead <= Read;
            r_addr   <= w_reqAddr;
            r_wdata  <= wdata;
            r_busy   <= 1'b1;
            r_cnt    <= WAIT_INIT;
            if (WAIT_INIT != 4'd0) r_state <= S_WAIT;
            else                   r_state <= S_ACCESS;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
          r_addrErr <= !w_addrValid;
          if (r_isRead) r_mdata <= w_addrValid ? r_mem[w_index] : '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM array has no reset; a clear during an access simply suppresses the write.
  always_ff @(posedge clk) begin
    if (w_doWrite) r_mem[w_index] <= r_wdata;
  end

  assign Mdatain   = r_mdata;
  assign mar_q     = r_mar;
  assign mem_busy  = r_busy;
  assign mem_ready = r_ready;
  assign addr_err  = r_addrErr;
  assign req_err   = r_reqErr;

endmodule
